// File: rtl/vga_pkg.sv
// Shared canvas geometry, VGA 640x480@60 timing constants and RGB444 layout
// for the frame scanner and its frame buffer.
package vga_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 60;
  localparam int SCALE_SHIFT  = 3;
  localparam int CANVAS_WORDS = COLS * ROWS;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // RGB444 word: R in [11:8], G in [7:4], B in [3:0].
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // row*80 + col, built from shifts so no multiplier is needed.
  function automatic logic [12:0] canvas_addr(input logic [6:0] col, input logic [5:0] row);
    return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame buffer RAM: one synchronous write port, one synchronous
// read port; a same-address collision returns the old word.
module fb_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/vga_frame_scanner.sv
// Stores an 80x60 RGB444 canvas and scans it out as 640x480@60 VGA with 8x8 upscaling.
// Define FB_DOUBLE_BUFFER_EN for a second bank with tear-free swaps at vertical blank.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_wr_col,
  input  logic [5:0]  i_wr_row,
  input  logic [11:0] i_wr_data,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_frame_tick,
  output logic        o_disp_bank
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             w_tick;
  logic             w_vis;
  logic             w_hs;
  logic             w_vs;
  logic             w_frame_start;
  logic             w_wr_ok;
  logic [12:0]      w_waddr;
  logic [12:0]      w_raddr;
  logic [11:0]      w_rdata;
  rgb444_t          w_pix;
  logic             r_vis_d;
  logic             r_hs_d;
  logic             r_vs_d;
  logic [3:0]       r_vga_r;
  logic [3:0]       r_vga_g;
  logic [3:0]       r_vga_b;
  logic             r_vga_hs;
  logic             r_vga_vs;
  logic             r_frame_tick;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == 10'(H_TOTAL - 1)) begin
        r_h <= '0;
        r_v <= (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  assign w_vis = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
  assign w_hs  = !((r_h >= 10'(H_VIS + H_FP)) && (r_h < 10'(H_VIS + H_FP + H_SYNC)));
  assign w_vs  = !((r_v >= 10'(V_VIS + V_FP)) && (r_v < 10'(V_VIS + V_FP + V_SYNC)));
  assign w_frame_start = w_tick && (r_h == 10'd0) && (r_v == 10'(V_VIS));

  assign w_wr_ok = (i_wr_col < 7'(COLS)) && (i_wr_row < 6'(ROWS));
  assign w_waddr = canvas_addr(i_wr_col, i_wr_row);
  assign w_raddr = canvas_addr(7'(r_h >> SCALE_SHIFT), 6'(r_v >> SCALE_SHIFT));
  assign w_pix   = rgb444_t'(w_rdata);

`ifdef FB_DOUBLE_BUFFER_EN
  logic        r_wb;
  logic        r_pending;
  logic        r_disp_bank;
  logic [6:0]  r_prev_col;
  logic [5:0]  r_prev_row;
  logic        w_frame_done;
  logic        w_swap;
  logic [13:0] w_bank_waddr;
  logic [13:0] w_bank_raddr;

  assign w_frame_done = (r_prev_col == 7'(COLS - 1)) && (r_prev_row == 6'(ROWS - 1)) &&
                        ((i_wr_col != r_prev_col) || (i_wr_row != r_prev_row));
  assign w_swap       = w_frame_start && r_pending;

  // Banks sit back to back: bank 1 starts at word CANVAS_WORDS.
  assign w_bank_waddr = r_wb ? (14'(w_waddr) + 14'(CANVAS_WORDS)) : 14'(w_waddr);
  assign w_bank_raddr = r_wb ? 14'(w_raddr) : (14'(w_raddr) + 14'(CANVAS_WORDS));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb        <= 1'b0;
      r_pending   <= 1'b0;
      r_disp_bank <= 1'b0;
      r_prev_col  <= '0;
      r_prev_row  <= '0;
    end else begin
      r_prev_col  <= i_wr_col;
      r_prev_row  <= i_wr_row;
      r_pending   <= w_frame_done | (r_pending & ~w_swap);
      if (w_swap) begin
        r_wb <= ~r_wb;
      end
      r_disp_bank <= w_swap ? r_wb : ~r_wb;
    end
  end

  fb_ram #(.DEPTH(2 * CANVAS_WORDS), .AW(14), .DW(12)) u_fb_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_bank_waddr),
    .i_wdata (i_wr_data),
    .i_raddr (w_bank_raddr),
    .o_rdata (w_rdata)
  );

  assign o_disp_bank = r_disp_bank;
`else
  fb_ram #(.DEPTH(CANVAS_WORDS), .AW(13), .DW(12)) u_fb_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_waddr),
    .i_wdata (i_wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign o_disp_bank = 1'b0;
`endif

  // Flags are delayed one clk to line up with the RAM read; CLK_DIV >= 2 lets both
  // settle before the tick that loads the outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vis_d <= 1'b0;
      r_hs_d  <= 1'b1;
      r_vs_d  <= 1'b1;
    end else begin
      r_vis_d <= w_vis;
      r_hs_d  <= w_hs;
      r_vs_d  <= w_vs;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vga_r      <= '0;
      r_vga_g      <= '0;
      r_vga_b      <= '0;
      r_vga_hs     <= 1'b1;
      r_vga_vs     <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_start;
      if (w_tick) begin
        r_vga_r  <= r_vis_d ? w_pix.r : 4'd0;
        r_vga_g  <= r_vis_d ? w_pix.g : 4'd0;
        r_vga_b  <= r_vis_d ? w_pix.b : 4'd0;
        r_vga_hs <= r_hs_d;
        r_vga_vs <= r_vs_d;
      end
    end
  end

  assign o_vga_r      = r_vga_r;
  assign o_vga_g      = r_vga_g;
  assign o_vga_b      = r_vga_b;
  assign o_vga_hs     = r_vga_hs;
  assign o_vga_vs     = r_vga_vs;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Downstream consumer of the ray-tracer host's pixel stream. Stores the 80x60 12-bit canvas in on-chip RAM as `(col, row, color)` arrives. Scans the canvas out as 640x480@60 VGA, scaling each canvas pixel to an 8x8 block. An optional second bank gives tear-free frame swaps.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per VGA pixel tick (100 MHz -> 25 MHz).

Ports:
- `clk`  in  1  system clock; everything is in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `wr_col`  in  7  canvas column of the incoming pixel, 0..79.
- `wr_row`  in  6  canvas row, 0..59.
- `wr_data`  in  12  RGB444 color {R[11:8], G[7:4], B[3:0]}.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  pixel color; 0 outside the visible area.
- `vga_hs`  out  1  horizontal sync, active low.
- `vga_vs`  out  1  vertical sync, active low.
- `frame_tick`  out  1  one-clock pulse at the start of vertical blank.
- `disp_bank`  out  1  bank currently displayed; constant 0 without `FB_DOUBLE_BUFFER_EN`.

## Operation
- **Write side**
  - Writes `wr_data` to `addr = wr_row*80 + wr_col` on every clk, computed as `(row<<6)+(row<<4)+col`, 13 bits.
  - Upstream changes address and color on the same edge, so each write is always a consistent pair.
  - Out-of-range input (col > 79 or row > 59) suppresses the write.
- **Tick generator**: divider counts 0..CLK_DIV-1; `tick` asserts when it is at CLK_DIV-1.
- **Scan counters** (advance on tick only)
  - `h` counts 0..799 and wraps.
  - `v` counts 0..524, increments when `h` wraps, and wraps to 0 after 524.
  - Visible area: `h<640 && v<480`.
  - `hs` is low for `h` in 656..751; `vs` is low for `v` in 490..491.
- **Read side**
  - Read address = `(v>>3)*80 + (h>>3)`.
  - RAM read is synchronous, one clk latency.
  - Visible flag, hs and vs are delayed in step with the read data.
  - Output registers load on tick.
- **frame_tick**: pulses on the clk where tick occurs with `h==0 && v==480`.
- **Frame completion**
  - Detected when the registered previous write address is (79,59) and the current address differs.
  - Sets `pending` (used only by the double buffer).

## Timing
- **Reset values**
  - `vga_r/g/b = 0`, `vga_hs = 1`, `vga_vs = 1`, `frame_tick = 0`, `disp_bank = 0`.
  - `h`, `v`, divider, `pending` and the write bank are all cleared.
  - RAM contents are not reset.
- **Reset mid-operation**: outputs return to reset values on the next clk; scanning restarts at h=v=0. With the double buffer, bank selects return to 0.
- **Output alignment**: outputs lag the counters by exactly one pixel tick. The RGB and sync outputs for counter state (h,v) appear on the tick after (h,v) was current.
- **Write-to-display latency**: a written pixel is visible from the next read of that address.
  - Without the double buffer, tearing is permitted.
  - With the double buffer, visible after the following swap.
- **Frame time**: 800*525 ticks = 420000*CLK_DIV clk between frame_tick pulses.
- **Read/write collision**: RAM reads and writes proceed every cycle with no arbitration. A same-address collision returns the old data.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined:
  - RAM holds 2x4800 words, address `{bank, addr}`.
  - Writes go to bank `wb`; display reads bank `~wb`, and `disp_bank = ~wb`.
  - On frame_tick with `pending=1`: `wb` toggles and `pending` clears.
  - Update rule: `pending_next = set | (pending & ~swap)`. A set coincident with a swap leaves `pending=1`.
- `FB_DOUBLE_BUFFER_EN` undefined:
  - Single 4800-word bank; no pending/swap logic.
  - `disp_bank` is tied 0.

## Structure
- **Shared package `vga_pkg`**
  - Canvas constants: COLS=80, ROWS=60, SCALE_SHIFT=3.
  - VGA timing constants: H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, V_VIS=480, V_FP=10, V_SYNC=2, V_BP=33.
  - RGB444 field positions.
- **Sub-module `fb_ram`**
  - Simple dual-port: one sync write port, one sync read port, parameterised depth.
  - Written so it infers block RAM.

## Test plan
- Assert rst for 3 clk -> all outputs at reset values; first `vga_hs` falling edge after exactly 656 ticks (+1 tick output lag).
- Write (5,3)=0xABC, all others 0 -> `vga_r/g/b = A/B/C` exactly for h 40..47, v 24..31; zero elsewhere.
- Free run two frames -> `vga_hs` low 96 ticks per line; `vga_vs` low 2 lines; frame_tick spacing 1,680,000 clk at CLK_DIV=4.
- Double buffer on: stream full frame of 0x0F0, then (79,59)->(0,0) -> display unchanged until next frame_tick, then green; `disp_bank` toggles once.
- Double buffer on: no frame completion -> `disp_bank` stays constant across 3 frame_ticks.
- rst pulsed at h=300, v=100 -> next clk outputs reset; first hs low after 656 ticks.
